// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and sends them as 8N1/8N2 frames, LSB first.
// Optional parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
module uart_tx_serializer #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 16
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic             stop2_i,
`ifdef UART_TX_PARITY_EN
   input  logic             parity_odd_i,
`endif
   input  logic             fifo_empty_i,
   output logic             fifo_ren_o,
   input  logic [WIDTH-1:0] fifo_rdata_i,
   input  logic             fifo_valid_i,
   output logic             tx_o,
   output logic             busy_o,
   output logic             tx_done_o
);
   localparam int BW = $clog2(WIDTH) + 1;
   typedef enum logic [2:0] {
      IDLE, FETCH, START, DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;
   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             stop2_q, stop2_d, tx_q, tx_d, ren_q, ren_d, done_q, done_d, busy_q, busy_d;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif
   assign bit_end    = cnt_q == div_q;
   assign fifo_ren_o = ren_q;
   assign tx_o       = tx_q;
   assign busy_o     = busy_q;
   assign tx_done_o  = done_q;
   // next-state logic: bit timing, frame sequencing and FIFO handshake
   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + DIV_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      div_d   = div_q;
      stop2_d = stop2_q;
      tx_d    = tx_q;
      ren_d   = 1'b0;
      done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (en_i && !fifo_empty_i) begin
               ren_d   = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (fifo_valid_i) begin
               shift_d = fifo_rdata_i;
               div_d   = div_i;
               stop2_d = stop2_i;
`ifdef UART_TX_PARITY_EN
               par_d   = ^fifo_rdata_i ^ parity_odd_i;
`endif
               tx_d    = 1'b0;
               cnt_d   = '0;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == BW'(WIDTH - 1)) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  bit_d   = bit_q + BW'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (bit_q == BW'(stop2_q)) begin
                  bit_d   = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
   end
   // state and registered outputs; reset drops the line high immediately
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         div_q   <= '0;
         stop2_q <= 1'b0;
         tx_q    <= 1'b1;
         ren_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         div_q   <= div_d;
         stop2_q <= stop2_d;
         tx_q    <= tx_d;
         ren_q   <= ren_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: frame-level model plus directed vectors for uart_tx_serializer.
module tb_uart_tx_serializer;
   logic        clk = 1'b0;
   logic        reset_ni = 1'b0;
   logic        en_i = 1'b0;
   logic [15:0] div_i = 16'd3;
   logic        stop2_i = 1'b0;
   logic        parity_odd = 1'b0;
   logic        fifo_empty_i;
   logic        fifo_ren_o;
   logic [7:0]  fifo_rdata_i = 8'h00;
   logic        fifo_valid_i = 1'b0;
   logic        tx_o, busy_o, tx_done_o;
   logic        no_valid = 1'b0;
   logic        ren_prev = 1'b0;
   logic [7:0]  fifo_q[$];
   typedef struct {logic tx; logic done;} ent_t;
   ent_t        exp_q[$];
   int          errors = 0, checks = 0, ren_cnt = 0, done_cnt = 0;

   uart_tx_serializer dut (
      .clk_i(clk), .reset_ni(reset_ni), .en_i(en_i), .div_i(div_i), .stop2_i(stop2_i),
`ifdef UART_TX_PARITY_EN
      .parity_odd_i(parity_odd),
`endif
      .fifo_empty_i(fifo_empty_i), .fifo_ren_o(fifo_ren_o), .fifo_rdata_i(fifo_rdata_i),
      .fifo_valid_i(fifo_valid_i), .tx_o(tx_o), .busy_o(busy_o), .tx_done_o(tx_done_o)
   );

   always #5 clk = ~clk;
   assign fifo_empty_i = fifo_q.size() == 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // expected line: start, data LSB first, [parity], stop bit(s), each div+1 cycles, then a done cycle
   task automatic push_frame(input logic [7:0] d, input int dv, input logic s2, input logic po);
      logic b[$];
      ent_t e;
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
      b.push_back(^d ^ po);
`endif
      b.push_back(1'b1);
      if (s2) b.push_back(1'b1);
      foreach (b[k]) begin
         e.tx = b[k];
         e.done = 1'b0;
         repeat (dv + 1) exp_q.push_back(e);
      end
      e.tx = 1'b1;
      e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   // per-cycle compare against the model, then play the FIFO read port
   always @(negedge clk) begin
      ent_t e;
      if (!reset_ni) begin
         exp_q.delete();
         check("rst_tx", tx_o, 1);
         check("rst_busy", busy_o, 0);
         check("rst_done", tx_done_o, 0);
         fifo_valid_i = 1'b0;
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_tx", tx_o, e.tx);
            check("frame_done", tx_done_o, e.done);
            check("frame_busy", busy_o, !e.done);
         end else begin
            check("idle_tx", tx_o, 1);
            check("idle_done", tx_done_o, 0);
         end
         if (fifo_ren_o) begin
            check("ren_single", ren_prev, 0);
            ren_cnt++;
         end
         if (tx_done_o) done_cnt++;
         fifo_valid_i = 1'b0;
         if (fifo_ren_o && fifo_q.size() > 0 && !no_valid) begin
            fifo_valid_i = 1'b1;
            fifo_rdata_i = fifo_q.pop_front();
            push_frame(fifo_rdata_i, int'(div_i), stop2_i, parity_odd);
         end else begin
            fifo_rdata_i = 8'h5A;
         end
      end
      ren_prev = fifo_ren_o;
   end

   task automatic wait_low(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!tx_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         errors++;
         checks++;
         $display("FAIL wait_start: no start bit within %0d cycles", bound);
      end
   endtask

   task automatic wait_done(input int target, input int bound);
      for (int i = 0; i < bound && done_cnt < target; i++) @(negedge clk);
      check("wait_done", done_cnt, target);
   endtask

   initial begin
      bit ok;
      int r0, d0, run, lows, busys;
      logic cap[40];
      logic dcap[25];
      logic [24:0] got, want;
      int exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
      repeat (3) @(negedge clk);
      check("reset_tx", tx_o, 1);
      check("reset_busy", busy_o, 0);
      check("reset_ren", fifo_ren_o, 0);
      check("reset_done", tx_done_o, 0);
      reset_ni = 1'b1;
      repeat (2) @(negedge clk);
      // 0xA5, div=3, one stop bit
      r0 = ren_cnt; d0 = done_cnt;
      en_i = 1'b1; div_i = 16'd3; stop2_i = 1'b0;
      fifo_q.push_back(8'hA5);
      wait_low(20, ok);
      for (int i = 0; i < 40; i++) begin
         if (i > 0) @(negedge clk);
         cap[i] = tx_o;
      end
      for (int b = 0; b < 10; b++)
         check($sformatf("t1_bit%0d", b), {cap[4*b], cap[4*b+1], cap[4*b+2], cap[4*b+3]}, {4{exp_bits[b][0]}});
      @(negedge clk);
      check("t1_done_pulse", tx_done_o, 1);
      repeat (3) @(negedge clk);
      check("t1_ren_count", ren_cnt - r0, 1);
      check("t1_done_count", done_cnt - d0, 1);
      // 0x00 then 0xFF, div=0, two stop bits, back to back
      r0 = ren_cnt; d0 = done_cnt;
      div_i = 16'd0; stop2_i = 1'b1;
      fifo_q.push_back(8'h00);
      fifo_q.push_back(8'hFF);
      wait_low(20, ok);
      for (int i = 0; i < 25; i++) begin
         if (i > 0) @(negedge clk);
         got[i] = tx_o;
         dcap[i] = tx_done_o;
         want[i] = !(i < 9 || i == 13);
      end
      check("t2_wave", got, want);
      check("t2_done_a", dcap[11], 1);
      check("t2_done_b", dcap[24], 1);
      repeat (3) @(negedge clk);
      check("t2_ren_count", ren_cnt - r0, 2);
      check("t2_done_count", done_cnt - d0, 2);
      // div changed 3 -> 7 during the first of two frames
      d0 = done_cnt;
      div_i = 16'd3; stop2_i = 1'b0;
      fifo_q.push_back(8'h3C);
      fifo_q.push_back(8'hC3);
      wait_low(20, ok);
      run = 0;
      do begin
         run++;
         @(negedge clk);
      end while (!tx_o && run < 100);
      check("t3_run_frame1", run, 12);
      div_i = 16'd7;
      wait_done(d0 + 1, 200);
      wait_low(20, ok);
      run = 0;
      do begin
         run++;
         @(negedge clk);
      end while (!tx_o && run < 100);
      check("t3_run_frame2", run, 8);
      wait_done(d0 + 2, 200);
      // FETCH without valid data
      en_i = 1'b0;
      repeat (3) @(negedge clk);
      r0 = ren_cnt; d0 = done_cnt;
      no_valid = 1'b1;
      fifo_q.push_back(8'h55);
      en_i = 1'b1;
      busys = 0; lows = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) en_i = 1'b0;
         busys += int'(busy_o);
         lows += int'(!tx_o);
      end
      check("t4_busy_cycles", busys, 1);
      check("t4_tx_low", lows, 0);
      check("t4_ren_count", ren_cnt - r0, 1);
      check("t4_done_count", done_cnt - d0, 0);
      fifo_q.delete();
      no_valid = 1'b0;
      // async reset during data bit 3
      div_i = 16'd3; en_i = 1'b1;
      fifo_q.push_back(8'hA5);
      wait_low(20, ok);
      repeat (17) @(negedge clk);
      check("t5_bit3_pre", tx_o, 0);
      #2 reset_ni = 1'b0;
      #1;
      check("t5_async_tx", tx_o, 1);
      check("t5_async_busy", busy_o, 0);
      repeat (2) @(negedge clk);
      reset_ni = 1'b1;
      r0 = ren_cnt;
      busys = 0; lows = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         busys += int'(busy_o);
         lows += int'(!tx_o);
      end
      check("t5_post_tx_low", lows, 0);
      check("t5_post_busy", busys, 0);
      check("t5_post_ren", ren_cnt - r0, 0);
`ifdef UART_TX_PARITY_EN
      // parity over 0x07: even gives 1, odd gives 0
      div_i = 16'd0; stop2_i = 1'b0;
      for (int p = 0; p < 2; p++) begin
         parity_odd = p[0];
         fifo_q.push_back(8'h07);
         wait_low(20, ok);
         for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            cap[i] = tx_o;
            dcap[i] = tx_done_o;
         end
         check($sformatf("par_bit_odd%0d", p), cap[9], !p[0]);
         check($sformatf("par_stop_odd%0d", p), cap[10], 1);
         check($sformatf("par_done_odd%0d", p), dcap[11], 1);
         repeat (3) @(negedge clk);
      end
`endif
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
